// File: rtl/debug_mem_master.sv
// debug_mem_master: burst master for port 2 of the core's DataRAM / InstRAM.
// Accepts read/write bursts on a command channel and returns read data or a write-completion beat.
module debug_mem_master #(
  parameter int RD_LAT = 1
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_sel,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [3:0]  cmd_be,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_last,
  output logic        busy,
  output logic [31:0] CPU_Debug_DataRAM_A2,
  output logic [31:0] CPU_Debug_InstRAM_A2,
  output logic [31:0] CPU_Debug_DataRAM_WD2,
  output logic [31:0] CPU_Debug_InstRAM_WD2,
  output logic [3:0]  CPU_Debug_DataRAM_WE2,
  output logic [3:0]  CPU_Debug_InstRAM_WE2,
  input  logic [31:0] CPU_Debug_DataRAM_RD2,
  input  logic [31:0] CPU_Debug_InstRAM_RD2
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RSP  = 3'd2,
    RD_WAIT = 3'd3,
    RD_RSP  = 3'd4
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t      state_r;
  logic        sel_r;
  logic [31:0] addr_r;
  logic [7:0]  remain_r;
  logic [3:0]  be_r;
  logic [2:0]  lat_cnt_r;
  logic [31:0] a2_r;
  logic [31:0] wd2_r;
  logic [3:0]  data_we_r;
  logic [3:0]  inst_we_r;

  logic [31:0] addr_next_s;
  logic [31:0] cmd_addr_al_s;
  logic [31:0] rd_data_s;

  // Address arithmetic wraps naturally at 2^32.
  assign addr_next_s   = addr_r + 32'd4;
  assign cmd_addr_al_s = cmd_addr & 32'hFFFF_FFFC;
  assign rd_data_s     = sel_r ? CPU_Debug_InstRAM_RD2 : CPU_Debug_DataRAM_RD2;

  assign CPU_Debug_DataRAM_A2  = a2_r;
  assign CPU_Debug_InstRAM_A2  = a2_r;
  assign CPU_Debug_DataRAM_WD2 = wd2_r;
  assign CPU_Debug_InstRAM_WD2 = wd2_r;
  assign CPU_Debug_DataRAM_WE2 = data_we_r;
  assign CPU_Debug_InstRAM_WE2 = inst_we_r;

  // Burst control FSM with registered channel and debug-port outputs.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      state_r   <= IDLE;
      sel_r     <= 1'b0;
      addr_r    <= 32'd0;
      remain_r  <= 8'd0;
      be_r      <= 4'd0;
      lat_cnt_r <= 3'd0;
      a2_r      <= 32'd0;
      wd2_r     <= 32'd0;
      data_we_r <= 4'd0;
      inst_we_r <= 4'd0;
      cmd_ready <= 1'b1;
      wr_ready  <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Write enables are single-cycle pulses unless a beat is taken below.
      data_we_r <= 4'd0;
      inst_we_r <= 4'd0;
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            sel_r     <= cmd_sel;
            addr_r    <= cmd_addr_al_s;
            remain_r  <= cmd_len;
            be_r      <= cmd_be;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_write) begin
              wr_ready <= 1'b1;
              state_r  <= WR;
            end else begin
              a2_r      <= cmd_addr_al_s;
              lat_cnt_r <= LAT_INIT;
              state_r   <= RD_WAIT;
            end
          end
        end
        WR: begin
          if (wr_valid) begin
            a2_r   <= addr_r;
            wd2_r  <= wr_data;
            addr_r <= addr_next_s;
            if (sel_r) begin
              inst_we_r <= be_r;
            end else begin
              data_we_r <= be_r;
            end
            if (remain_r == 8'd0) begin
              wr_ready <= 1'b0;
              state_r  <= WR_RSP;
            end else begin
              remain_r <= remain_r - 8'd1;
            end
          end
        end
        WR_RSP: begin
          // First cycle here is the last WE2 pulse; the completion beat follows it.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= 32'd0;
            rsp_last  <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state_r   <= IDLE;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_r == 3'd0) begin
            rsp_rdata <= rd_data_s;
            rsp_last  <= (remain_r == 8'd0);
            rsp_valid <= 1'b1;
            state_r   <= RD_RSP;
          end else begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end
        end
        RD_RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              rsp_last  <= 1'b0;
              cmd_ready <= 1'b1;
              busy      <= 1'b0;
              state_r   <= IDLE;
            end else begin
              remain_r  <= remain_r - 8'd1;
              addr_r    <= addr_next_s;
              a2_r      <= addr_next_s;
              lat_cnt_r <= LAT_INIT;
              state_r   <= RD_WAIT;
            end
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          rsp_last  <= 1'b0;
          wr_ready  <= 1'b0;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_mem_master.sv
// tb_debug_mem_master: directed checks of debug_mem_master, one instance with RD_LAT=1 and one with RD_LAT=3.
`timescale 1ns/1ps
module tb_debug_mem_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_valid, cmd_valid3, cmd_write, cmd_sel, wr_valid, rsp_ready;
  logic [31:0] cmd_addr, wr_data;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_be;

  logic        cmd_ready1, wr_ready1, rsp_valid1, rsp_last1, busy1;
  logic [31:0] rsp_rdata1, d_a2, i_a2, d_wd2, i_wd2, d_rd2, i_rd2;
  logic [3:0]  d_we2, i_we2;

  logic        cmd_ready3, wr_ready3, rsp_valid3, rsp_last3, busy3;
  logic [31:0] rsp_rdata3, d_a2_3, i_a2_3, d_wd2_3, i_wd2_3, d_rd2_3, i_rd2_3, d3_p1, d3_p2;
  logic [3:0]  d_we2_3, i_we2_3;

  debug_mem_master #(.RD_LAT(1)) u_dut1 (
    .CPU_CLK(clk), .CPU_RST(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_data(wr_data),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata1), .rsp_last(rsp_last1), .busy(busy1),
    .CPU_Debug_DataRAM_A2(d_a2), .CPU_Debug_InstRAM_A2(i_a2),
    .CPU_Debug_DataRAM_WD2(d_wd2), .CPU_Debug_InstRAM_WD2(i_wd2),
    .CPU_Debug_DataRAM_WE2(d_we2), .CPU_Debug_InstRAM_WE2(i_we2),
    .CPU_Debug_DataRAM_RD2(d_rd2), .CPU_Debug_InstRAM_RD2(i_rd2));

  debug_mem_master #(.RD_LAT(3)) u_dut3 (
    .CPU_CLK(clk), .CPU_RST(rst), .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_be(cmd_be),
    .wr_valid(wr_valid), .wr_ready(wr_ready3), .wr_data(wr_data),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata3), .rsp_last(rsp_last3), .busy(busy3),
    .CPU_Debug_DataRAM_A2(d_a2_3), .CPU_Debug_InstRAM_A2(i_a2_3),
    .CPU_Debug_DataRAM_WD2(d_wd2_3), .CPU_Debug_InstRAM_WD2(i_wd2_3),
    .CPU_Debug_DataRAM_WE2(d_we2_3), .CPU_Debug_InstRAM_WE2(i_we2_3),
    .CPU_Debug_DataRAM_RD2(d_rd2_3), .CPU_Debug_InstRAM_RD2(i_rd2_3));

  // Data RAM contents: three known words at 0x200, an address hash elsewhere.
  function automatic logic [31:0] dmem_f(input logic [31:0] a);
    case (a)
      32'h0000_0200: return 32'h0000_000A;
      32'h0000_0204: return 32'h0000_000B;
      32'h0000_0208: return 32'h0000_000C;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  // RAM models with RD_LAT pipeline stages (InstRAM returns ~address).
  always @(posedge clk) begin
    d_rd2   <= dmem_f(d_a2);
    i_rd2   <= ~i_a2;
    d3_p1   <= dmem_f(d_a2_3);
    d3_p2   <= d3_p1;
    d_rd2_3 <= d3_p2;
    i_rd2_3 <= ~i_a2_3;
  end

  typedef struct { logic [31:0] a2; logic [31:0] wd; logic [3:0] we; int cyc; } wr_ev_t;
  typedef struct { logic [31:0] rdata; logic [31:0] a2; logic last; int cyc; } rsp_ev_t;
  wr_ev_t  iwq[$], dwq[$];
  rsp_ev_t rq[$], rq3[$];
  int cyc = 0;
  int port_diff = 0;
  int we3_seen = 0;

  // Edge monitors: WE2 pulses, response handshakes, and equality of the paired debug ports.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_we2 != 4'd0) iwq.push_back('{i_a2, i_wd2, i_we2, cyc});
    if (d_we2 != 4'd0) dwq.push_back('{d_a2, d_wd2, d_we2, cyc});
    if (rsp_valid1 && rsp_ready) rq.push_back('{rsp_rdata1, d_a2, rsp_last1, cyc});
    if (rsp_valid3 && rsp_ready) rq3.push_back('{rsp_rdata3, d_a2_3, rsp_last3, cyc});
    if (d_a2 != i_a2 || d_wd2 != i_wd2 || d_a2_3 != i_a2_3 || d_wd2_3 != i_wd2_3) port_diff <= port_diff + 1;
    if (d_we2_3 != 4'd0 || i_we2_3 != 4'd0 || wr_ready3) we3_seen <= we3_seen + 1;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_q();
    iwq.delete(); dwq.delete(); rq.delete();
  endtask

  // Offer one command to the RD_LAT=1 instance; called at a negedge while idle.
  task automatic issue(input logic w, input logic s, input logic [31:0] a, input logic [7:0] l, input logic [3:0] b);
    check("cmd_ready_before_issue", 32'(cmd_ready1), 32'd1);
    cmd_write = w; cmd_sel = s; cmd_addr = a; cmd_len = l; cmd_be = b;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", 32'(busy1), 32'd1);
  endtask

  task automatic wait_idle(input int limit, input string name);
    int n = 0;
    while (busy1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(busy1), 32'd0);
  endtask

  typedef struct { logic sel; logic [31:0] addr; logic [31:0] exp_a2; logic [31:0] exp_rdata; } rd_vec_t;
  rd_vec_t vecs[5];

  initial begin
    logic [31:0] wdat[4];
    logic [31:0] rexp[3];
    int n, err_d, err_a, err_g, err_l;

    vecs[0] = '{1'b0, 32'h0000_0204, 32'h0000_0204, 32'h0000_000B};
    vecs[1] = '{1'b1, 32'h0000_1237, 32'h0000_1234, 32'hFFFF_EDCB};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h2152_FFFC};
    vecs[3] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF};
    vecs[4] = '{1'b0, 32'h8000_0001, 32'h8000_0000, 32'h5EAD_0000};
    wdat = '{32'h11, 32'h22, 32'h33, 32'h44};
    rexp = '{32'hA, 32'hB, 32'hC};

    cmd_valid = 1'b0; cmd_valid3 = 1'b0; cmd_write = 1'b0; cmd_sel = 1'b0;
    cmd_addr = 32'd0; cmd_len = 8'd0; cmd_be = 4'd0;
    wr_valid = 1'b0; wr_data = 32'd0; rsp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready1), 32'd1);
    check("rst_wr_ready", 32'(wr_ready1), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
    check("rst_rsp_rdata", rsp_rdata1, 32'd0);
    check("rst_rsp_last", 32'(rsp_last1), 32'd0);
    check("rst_busy", 32'(busy1), 32'd0);
    check("rst_a2", d_a2 | i_a2 | d_wd2 | i_wd2, 32'd0);
    check("rst_we2", 32'({d_we2, i_we2}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready1), 32'd1);

    // 4-word InstRAM write at 0x100
    clear_q();
    issue(1'b1, 1'b1, 32'h100, 8'd3, 4'hF);
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_data = wdat[i];
      @(negedge clk);
    end
    wr_valid = 1'b0;
    wait_idle(20, "wr4_done");
    check("wr4_inst_beats", 32'(iwq.size()), 32'd4);
    check("wr4_data_beats", 32'(dwq.size()), 32'd0);
    check("wr4_rsp_beats", 32'(rq.size()), 32'd1);
    if (iwq.size() == 4 && rq.size() == 1) begin
      for (int i = 0; i < 4; i++) begin
        check("wr4_a2", iwq[i].a2, 32'h100 + 32'(4 * i));
        check("wr4_wd2", iwq[i].wd, wdat[i]);
        check("wr4_we2", 32'(iwq[i].we), 32'hF);
        check("wr4_consecutive", 32'(iwq[i].cyc - iwq[0].cyc), 32'(i));
      end
      check("wr4_rsp_rdata", rq[0].rdata, 32'd0);
      check("wr4_rsp_last", 32'(rq[0].last), 32'd1);
      check("wr4_rsp_after_we", 32'(rq[0].cyc - iwq[3].cyc), 32'd1);
    end

    // 3-word DataRAM read at 0x203, with write-channel noise
    clear_q();
    wr_valid = 1'b1; wr_data = 32'hBAD0_BAD0;
    issue(1'b0, 1'b0, 32'h203, 8'd2, 4'hF);
    wait_idle(40, "rd3_done");
    wr_valid = 1'b0;
    check("rd3_beats", 32'(rq.size()), 32'd3);
    check("rd3_no_writes", 32'(dwq.size() + iwq.size()), 32'd0);
    if (rq.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("rd3_a2", rq[k].a2, 32'h200 + 32'(4 * k));
        check("rd3_rdata", rq[k].rdata, rexp[k]);
        check("rd3_last", 32'(rq[k].last), 32'(k == 2));
        if (k > 0) check("rd3_period", 32'(rq[k].cyc - rq[k-1].cyc), 32'd3);
      end
    end

    // Single-beat read vectors
    for (int v = 0; v < 5; v++) begin
      clear_q();
      issue(1'b0, vecs[v].sel, vecs[v].addr, 8'd0, 4'hF);
      wait_idle(20, "vec_done");
      check("vec_beats", 32'(rq.size()), 32'd1);
      if (rq.size() == 1) begin
        check("vec_a2", rq[0].a2, vecs[v].exp_a2);
        check("vec_rdata", rq[0].rdata, vecs[v].exp_rdata);
        check("vec_last", 32'(rq[0].last), 32'd1);
      end
    end

    // Backpressure on beat 1 for 5 cycles
    clear_q();
    rsp_ready = 1'b0;
    issue(1'b0, 1'b0, 32'h200, 8'd1, 4'hF);
    n = 0;
    while (!rsp_valid1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid_rise", 32'(rsp_valid1), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid_hold", 32'(rsp_valid1), 32'd1);
      check("bp_rdata_hold", rsp_rdata1, 32'hA);
      check("bp_last_hold", 32'(rsp_last1), 32'd0);
      check("bp_a2_hold", d_a2, 32'h200);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    wait_idle(20, "bp_done");
    check("bp_beats", 32'(rq.size()), 32'd2);
    if (rq.size() == 2) begin
      check("bp_b0_rdata", rq[0].rdata, 32'hA);
      check("bp_b0_last", 32'(rq[0].last), 32'd0);
      check("bp_b1_rdata", rq[1].rdata, 32'hB);
      check("bp_b1_a2", rq[1].a2, 32'h204);
      check("bp_b1_last", 32'(rq[1].last), 32'd1);
    end

    // Wrapping DataRAM write with partial byte enables
    clear_q();
    issue(1'b1, 1'b0, 32'hFFFF_FFFC, 8'd1, 4'b0011);
    wr_valid = 1'b1; wr_data = 32'h55;
    @(negedge clk);
    wr_data = 32'h66;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_idle(20, "wrap_done");
    check("wrap_data_beats", 32'(dwq.size()), 32'd2);
    check("wrap_inst_beats", 32'(iwq.size()), 32'd0);
    check("wrap_rsp_beats", 32'(rq.size()), 32'd1);
    if (dwq.size() == 2) begin
      check("wrap_a2_0", dwq[0].a2, 32'hFFFF_FFFC);
      check("wrap_a2_1", dwq[1].a2, 32'h0000_0000);
      check("wrap_we_0", 32'(dwq[0].we), 32'h3);
      check("wrap_we_1", 32'(dwq[1].we), 32'h3);
    end

    // Reset in the middle of an 8-beat InstRAM write
    clear_q();
    issue(1'b1, 1'b1, 32'h400, 8'd7, 4'hF);
    wr_valid = 1'b1; wr_data = 32'h1;
    @(negedge clk);
    wr_data = 32'h2;
    @(negedge clk);
    wr_valid = 1'b0;
    check("mid_we_pulse", 32'(i_we2), 32'hF);
    check("mid_a2", i_a2, 32'h404);
    #1 rst = 1'b1;
    #1;
    check("async_we_clear", 32'({i_we2, d_we2}), 32'd0);
    check("async_a2_clear", i_a2 | d_wd2, 32'd0);
    check("async_busy", 32'(busy1), 32'd0);
    check("async_cmd_ready", 32'(cmd_ready1), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_busy", 32'(busy1), 32'd0);
    check("rel_cmd_ready", 32'(cmd_ready1), 32'd1);
    check("rel_no_rsp", 32'(rq.size()), 32'd0);
    check("rel_inst_beats", 32'(iwq.size()), 32'd1);
    clear_q();
    issue(1'b0, 1'b1, 32'h40, 8'd0, 4'hF);
    wait_idle(20, "rel_rd_done");
    check("rel_rd_beats", 32'(rq.size()), 32'd1);
    if (rq.size() == 1) begin
      check("rel_rd_rdata", rq[0].rdata, 32'hFFFF_FFBF);
      check("rel_rd_last", 32'(rq[0].last), 32'd1);
    end

    // RD_LAT=3 instance: 256-beat read, rsp_ready held high
    rq3.delete();
    check("lat3_cmd_ready", 32'(cmd_ready3), 32'd1);
    cmd_write = 1'b0; cmd_sel = 1'b0; cmd_addr = 32'h3000; cmd_len = 8'd255; cmd_be = 4'hF;
    cmd_valid3 = 1'b1;
    @(negedge clk);
    cmd_valid3 = 1'b0;
    n = 0;
    while (busy3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("lat3_done", 32'(busy3), 32'd0);
    check("lat3_beats", 32'(rq3.size()), 32'd256);
    err_d = 0; err_a = 0; err_g = 0; err_l = 0;
    for (int k = 0; k < rq3.size(); k++) begin
      if (rq3[k].a2 != 32'h3000 + 32'(4 * k)) err_a++;
      if (rq3[k].rdata != dmem_f(32'h3000 + 32'(4 * k))) err_d++;
      if (k > 0 && rq3[k].cyc - rq3[k-1].cyc != 5) err_g++;
      if (rq3[k].last != (k == 255)) err_l++;
    end
    check("lat3_addr_errs", 32'(err_a), 32'd0);
    check("lat3_data_errs", 32'(err_d), 32'd0);
    check("lat3_period_errs", 32'(err_g), 32'd0);
    check("lat3_last_errs", 32'(err_l), 32'd0);
    check("lat3_no_write_activity", 32'(we3_seen), 32'd0);
    check("port_pair_equal", 32'(port_diff), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_mem_master.md
# debug_mem_master

Host-side master for the core's debug memory ports (`CPU_Debug_DataRAM_*` / `CPU_Debug_InstRAM_*`, port 2 of each RAM). It accepts burst read/write commands over a valid/ready command channel and streams write data in over a write channel. It drives word-aligned accesses on the selected RAM's debug port and returns read data, or a write-completion beat, on a response channel. It sits outside `RV32Core` and is used by the loader/test harness to program instruction memory and inspect data memory.

## Interface
- `RD_LAT`, default 1, cycles from `*_A2` being driven until `*_RD2` is valid (range 1..4).

- `CPU_CLK`  in  1  clock; all logic on rising edge.
- `CPU_RST`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command; high only in IDLE.
- `cmd_write`  in  1  1 = write burst, 0 = read burst.
- `cmd_sel`  in  1  0 = DataRAM, 1 = InstRAM.
- `cmd_addr`  in  32  start byte address; bits [1:0] forced to 0.
- `cmd_len`  in  8  beats minus 1 (0 → 1 beat, 255 → 256 beats).
- `cmd_be`  in  4  byte enables applied to every write beat.
- `wr_valid`  in  1  write data beat offered.
- `wr_ready`  out  1  write beat accepted; high in WR state.
- `wr_data`  in  32  write data.
- `rsp_valid`  out  1  response beat valid.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_rdata`  out  32  read data; 0 for write-completion beat.
- `rsp_last`  out  1  final beat of burst.
- `busy`  out  1  state != IDLE.
- `CPU_Debug_DataRAM_A2`, `CPU_Debug_InstRAM_A2`  out  32  debug address (both carry the same value).
- `CPU_Debug_DataRAM_WD2`, `CPU_Debug_InstRAM_WD2`  out  32  debug write data (same value).
- `CPU_Debug_DataRAM_WE2`, `CPU_Debug_InstRAM_WE2`  out  4  byte write enables; only the selected RAM is ever nonzero.
- `CPU_Debug_DataRAM_RD2`, `CPU_Debug_InstRAM_RD2`  in  32  read data.

## Operation
- States: IDLE, WR, WR_RSP, RD_WAIT, RD_RSP.
- Internal registers: `sel`, `addr`, `remain` (8-bit), `be`, `lat_cnt`. All debug-port outputs are registered.
- IDLE: `cmd_valid & cmd_ready` latches `sel`, `addr = {cmd_addr[31:2],2'b00}`, `remain = cmd_len`, `be`.
  - If `cmd_write` = 1, go to WR.
  - If `cmd_write` = 0, load `A2 = addr` and `lat_cnt = RD_LAT`, then go to RD_WAIT.
- WR: `wr_ready` = 1. On `wr_valid`:
  - Register `A2 = addr`, `WD2 = wr_data`, `WE2[sel] = be`.
  - Advance `addr += 4`.
  - If `remain` = 0, go to WR_RSP; otherwise `remain -= 1`.
  - Cycles with no accepted beat register WE2 = 0. Each WE2 is a single-cycle pulse per beat.
- WR_RSP: WE2 = 0. Assert `rsp_valid=1`, `rsp_rdata=0`, `rsp_last=1`. On `rsp_ready`, go to IDLE.
- RD_WAIT: `lat_cnt` decrements each cycle.
  - When `lat_cnt` = 0, capture the selected RAM's RD2 into `rsp_rdata` and set `rsp_last = (remain==0)`, then go to RD_RSP.
- RD_RSP: `rsp_valid` = 1, held stable until `rsp_ready`. On the handshake:
  - If last, go to IDLE.
  - Otherwise `remain -= 1`, `addr += 4`, `A2 = addr+4`, `lat_cnt = RD_LAT`, and go to RD_WAIT.
- Address increment wraps modulo 2^32 (0xFFFFFFFC + 4 → 0x00000000).
- `cmd_be` = 0: beats are still consumed and WE2 stays 0. The completion beat is still produced.
- The write response is issued only after the last WE2 pulse has been driven.

## Timing
- Reset (async assert) values:
  - state IDLE, `cmd_ready=1`, `wr_ready=0`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_last=0`, `busy=0`.
  - All A2/WD2 = 0 and all WE2 = 0, taking effect immediately, including in the middle of a burst.
  - The burst is abandoned; no response is produced.
- Write: beat accepted at edge t drives WE2 during cycle t+1. Sustained rate is 1 beat/cycle. `rsp_valid` rises in the cycle after the last WE2 pulse.
- Read: `A2` valid in cycle c, RD2 sampled at the end of cycle c+RD_LAT, `rsp_valid` high from cycle c+RD_LAT+1. With `rsp_ready` held high, throughput is RD_LAT+2 cycles per word.
- `cmd_ready` is low from the accept edge until the edge after the final response handshake. A new command can be accepted in the first IDLE cycle.
- `wr_valid` outside WR is ignored. Read data is not affected by `wr_*`.
- Response backpressure: `rsp_rdata` and `rsp_last` stay stable while `rsp_valid & ~rsp_ready`. A2 does not advance.

## Test plan
- Write 4 words to InstRAM at 0x100 (`cmd_len=3`, `be=F`, data 0x11,0x22,0x33,0x44 back-to-back) → Inst WE2=F on 4 consecutive cycles with A2 = 0x100/104/108/10C, Data WE2 stays 0, then one response beat with `rsp_last=1`, `rdata=0`.
- Read 3 words from DataRAM at 0x203 (model RAM contents 0xA,0xB,0xC at 0x200..0x208) → A2 = 0x200,0x204,0x208 and responses 0xA,0xB,0xC with `rsp_last` only on the third.
- Read with `rsp_ready` low for 5 cycles on beat 1 (`RD_LAT=1`) → `rsp_valid`, `rsp_rdata` and A2 stay frozen; no beat is lost or duplicated.
- Write burst at 0xFFFFFFFC, `len=1`, `be=4'b0011` → A2 = 0xFFFFFFFC then 0x00000000, with WE2=0011 on both beats.
- Assert CPU_RST mid-write after beat 2 of 8 → WE2 goes to 0 without waiting for a clock edge, `cmd_ready=1` and `busy=0` after release, and a following 1-word read completes correctly.
- `RD_LAT=3`, 256-beat read (`cmd_len=255`) with `rsp_ready` held high → exactly 256 beats at 5 cycles each, last flagged on beat 256.
